// File: rtl/or1200_wb_sram_slave_if.sv
// Wishbone classic bus bundle between an OR1200 iwb/dwb master and an SRAM slave.
// Signal names follow the slave's view of the bus.
interface or1200_wb_sram_slave_if;
  logic        cyc_i;
  logic        stb_i;
  logic        we_i;
  logic [3:0]  sel_i;
  logic [31:0] adr_i;
  logic [31:0] dat_i;
  logic        cab_i;
  logic [31:0] dat_o;
  logic        ack_o;
  logic        err_o;
  logic        rty_o;

  modport slave (
    input  cyc_i, stb_i, we_i, sel_i, adr_i, dat_i, cab_i,
    output dat_o, ack_o, err_o, rty_o
  );

  modport master (
    output cyc_i, stb_i, we_i, sel_i, adr_i, dat_i, cab_i,
    input  dat_o, ack_o, err_o, rty_o
  );
endinterface

// File: rtl/or1200_wb_sram_slave.sv
// Wishbone classic SRAM slave with programmable wait states and out-of-window error response.
// Optional macro OR1200_WBSLV_CAB_EN: consecutive-address bursts skip the wait states after the first beat.
module or1200_wb_sram_slave #(
  parameter int          MEM_AW      = 10,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic clk_i,
  input  logic rst_n_i,
  or1200_wb_sram_slave_if.slave wb
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  generate
    if ((WAIT_CYCLES > 15) || (WAIT_CYCLES < 0)) begin : g_wait_range_check
      $error("or1200_wb_sram_slave: WAIT_CYCLES must be in 0..15");
    end
  endgenerate

  logic [31:0]       mem_r [0:(2**MEM_AW)-1];
  state_t            state_r;
  logic [3:0]        cnt_r;
  logic              ack_r;
  logic              err_r;
  logic [31:0]       dat_r;
  logic              burst_s;
  logic [31:0]       offs_s;
  logic              hit_s;
  logic [MEM_AW-1:0] idx_s;
  logic              req_s;
  logic              enter_resp_s;
  logic              mem_we_s;

  // Address decode and the decision to respond on this edge
  always_comb begin
    offs_s       = wb.adr_i - BASE_ADDR;
    hit_s        = ((offs_s >> (MEM_AW + 2)) == 32'd0);
    idx_s        = offs_s[MEM_AW+1:2];
    req_s        = wb.cyc_i & wb.stb_i;
    enter_resp_s = 1'b0;
    case (state_r)
      IDLE:    enter_resp_s = req_s & ((WAIT_CYCLES == 0) | burst_s);
      WAIT:    enter_resp_s = req_s & (cnt_r == 4'd0);
      default: enter_resp_s = 1'b0;
    endcase
    mem_we_s = enter_resp_s & wb.we_i & hit_s & rst_n_i;
  end

  // Transfer FSM with registered terminations and read data
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      ack_r   <= 1'b0;
      err_r   <= 1'b0;
      dat_r   <= 32'd0;
    end else begin
      ack_r <= 1'b0;
      err_r <= 1'b0;
      if (enter_resp_s) begin
        state_r <= RESP;
        ack_r   <= hit_s;
        err_r   <= ~hit_s;
        if (hit_s && !wb.we_i) begin
          dat_r <= mem_r[idx_s];
        end
      end else begin
        case (state_r)
          IDLE: begin
            if (req_s) begin
              state_r <= WAIT;
              cnt_r   <= CNT_LOAD;
            end
          end
          WAIT: begin
            // A dropped request abandons the transfer silently
            if (!req_s) begin
              state_r <= IDLE;
            end else begin
              cnt_r <= cnt_r - 4'd1;
            end
          end
          RESP:    state_r <= IDLE;
          default: state_r <= IDLE;
        endcase
      end
    end
  end

  // Byte-lane writes; contents survive reset
  always_ff @(posedge clk_i) begin
    if (mem_we_s) begin
      for (int b = 0; b < 4; b++) begin
        if (wb.sel_i[b]) begin
          mem_r[idx_s][8*b +: 8] <= wb.dat_i[8*b +: 8];
        end
      end
    end
  end

`ifdef OR1200_WBSLV_CAB_EN
  logic burst_r;

  // Burst flag: armed by a hit response inside a cab cycle, dropped as soon as cab or cyc goes away
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      burst_r <= 1'b0;
    end else if (!(wb.cyc_i & wb.cab_i)) begin
      burst_r <= 1'b0;
    end else if ((state_r == RESP) && ack_r) begin
      burst_r <= 1'b1;
    end
  end

  assign burst_s = burst_r;
`else
  assign burst_s = 1'b0;
`endif

  assign wb.ack_o = ack_r;
  assign wb.err_o = err_r;
  assign wb.dat_o = dat_r;
  assign wb.rty_o = 1'b0;

endmodule
